// File: rtl/lsu_pkg.sv
// Shared decode constants, state encoding and op-legality helpers for the load/store unit.
// Misalignment trapping is selected in load_store_unit by LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_BUS  = 2'd1;
  localparam lsu_state_t ST_DONE = 2'd2;

  // Only the RV32I load/store encodings are accepted.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else    ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
    return ok;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  // Halfword and word accesses snap to their natural boundary.
  always_comb begin
    lane    = addr_lo_i;
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << lane;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        lane    = {addr_lo_i[1], 1'b0};
        be_o    = 4'b0011 << lane;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        lane    = 2'b00;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
    shifted = bus_rdata_i >> {lane, 3'b000};
    case (funct3_i[1:0])
      2'b00:   rdata_o = funct3_i[2] ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   rdata_o = funct3_i[2] ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: captures one op, runs a valid/ack bus access, stalls the pipe.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of snapping them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              lsu_stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  lsu_state_t        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              fault_q, fault_d;
  logic              op_bad;

  logic              in_bus;
  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;

  // The aligner sees the live request in IDLE and the captured op while on the bus.
  assign in_bus = (state_q == ST_BUS);
  assign al_f3  = in_bus ? f3_q  : req_funct3;
  assign al_off = in_bus ? off_q : req_addr[1:0];

  lsu_align u_align (
    .funct3_i    (al_f3),
    .addr_lo_i   (al_off),
    .wdata_i     (req_wdata),
    .bus_rdata_i (bus_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  assign lsu_stall = ~reset & (((state_q == ST_IDLE) & req_valid) | in_bus);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    f3_d          = f3_q;
    off_d         = off_q;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    fault_d       = fault_q;
    op_bad        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
          op_bad = ~lsu_legal(req_we, req_funct3) | lsu_misaligned(req_funct3, req_addr[1:0]);
`else
          op_bad = ~lsu_legal(req_we, req_funct3);
`endif
          if (op_bad) begin
            state_d       = ST_DONE;
            rdata_valid_d = 1'b1;
            fault_d       = 1'b1;
            rdata_d       = '0;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = al_be;
            bus_wdata_d = req_we ? al_wdata : 32'd0;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          state_d       = ST_DONE;
          bus_req_d     = 1'b0;
          rdata_valid_d = 1'b1;
          fault_d       = 1'b0;
          rdata_d       = bus_we_q ? 32'd0 : al_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = ST_DONE;
          bus_req_d     = 1'b0;
          rdata_valid_d = 1'b1;
          fault_d       = 1'b1;
          rdata_d       = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      f3_q          <= '0;
      off_q         <= '0;
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random checks of load_store_unit against a byte-arithmetic reference model.
module tb_load_store_unit;

  localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        lsu_stall;
  logic [31:0] rdata;
  logic        rdata_valid, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata = 32'd0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .lsu_stall(lsu_stall), .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, lane = address rounded down to the size, byte i of store data = wdata byte (i mod size).
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rword,
                       output bit ill, output logic [31:0] eaddr, output logic [3:0] ebe,
                       output logic [31:0] ewd, output logic [31:0] erd);
    int unsigned size, lane;
    bit legal;
    longint unsigned v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    if (size > 4) size = 4;
    ill   = !legal || (TRAP && ((addr % size) != 0));
    lane  = (addr % 4) - ((addr % 4) % size);
    eaddr = addr - (addr % 4);
    ebe   = 4'(((1 << size) - 1) << lane);
    ewd   = 32'd0;
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    v = (64'(rword) >> (8 * lane)) % (64'd1 << (8 * size));
    if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
    erd = 32'(v);
  endtask

  // ack_lat = index of the bus cycle that sees bus_ack; >= TMO means never acked.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rword, input int ack_lat);
    bit ill, efault, done;
    logic [31:0] eaddr, ewd, erd, erd_fin;
    logic [3:0] ebe;
    int stalls, bcyc, exp_bcyc, exp_stall;
    model(we, f3, addr, wd, rword, ill, eaddr, ebe, ewd, erd);
    efault    = ill || (ack_lat >= TMO);
    exp_bcyc  = ill ? 0 : ((ack_lat >= TMO) ? TMO : ack_lat + 1);
    exp_stall = ill ? 1 : exp_bcyc + 1;
    erd_fin   = (efault || we) ? 32'd0 : erd;
    @(negedge clk);
    chk("rdata_hold", rdata, last_rdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    stalls = 0; bcyc = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (lsu_stall) stalls++;
      if (rdata_valid) begin
        done = 1'b1;
      end else begin
        if (bus_req) begin
          chk("bus_addr", bus_addr, eaddr);
          chk("bus_be", 32'(bus_be), 32'(ebe));
          chk("bus_we", 32'(bus_we), 32'(we));
          if (we) chk("bus_wdata", bus_wdata, ewd);
          bus_ack   = (bcyc == ack_lat);
          bus_rdata = (bcyc == ack_lat) ? rword : $urandom;
          bcyc++;
        end else begin
          bus_ack   = 1'($urandom);
          bus_rdata = $urandom;
        end
        @(negedge clk);
      end
    end
    chk("completed", 32'(done), 32'd1);
    chk("fault", 32'(fault), 32'(efault));
    chk("rdata", rdata, erd_fin);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("bus_cycles", 32'(bcyc), 32'(exp_bcyc));
    last_rdata = erd_fin;
    bus_ack = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] f3;
    logic we;
    bit seen;

    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h100; req_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    @(negedge clk); #1;
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_valid", 32'(rdata_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;

    run_op(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0);
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0);
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF7F01, 0);
    run_op(1'b1, 3'b000, 32'h101, 32'h123456AB, 32'h0, 0);
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h11223344, 99);
    run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 2);
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0);
    run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    run_op(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0);
    run_op(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_F300, 1);
    run_op(1'b1, 3'b001, 32'h106, 32'h0000BEEF, 32'h0, 3);

    // Reset in the middle of a bus access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; bus_ack = 1'b0;
    @(negedge clk); #1;
    chk("mid_bus_req", 32'(bus_req), 32'd1);
    @(negedge clk); #1;
    reset = 1'b1; #1;
    chk("rst_drop_req", 32'(bus_req), 32'd0);
    chk("rst_drop_stall", 32'(lsu_stall), 32'd0);
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rdata_valid) seen = 1'b1;
    end
    chk("rst_no_valid", 32'(seen), 32'd0);
    last_rdata = 32'd0;

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = lf[$urandom_range(0, 4)];
      run_op(we, f3, 32'h1000 + 32'($urandom_range(0, 255)), $urandom, $urandom,
             $urandom_range(0, 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting between the EX/MEM pipeline register and the data-memory bus. It accepts one load or store per pipeline slot, performs RV32I byte/half/word lane steering with sign/zero extension, runs a valid/ack handshake with a variable-latency memory, and holds the pipeline via `lsu_stall` until the access completes or faults. It replaces a direct single-cycle data-memory hookup.

## Interface
- `ADDR_W`, 32: address width.
- `TIMEOUT_CYCLES`, 255: bus cycles to wait for `bus_ack` before faulting; 0 disables the timeout.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: EX/MEM holds a memory op (MemRead|MemWrite).
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access size/sign from the instruction.
- `req_addr` in ADDR_W: byte address (ALU result).
- `req_wdata` in 32: store data (forwarded rs2).
- `lsu_stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `rdata` out 32: formatted load result.
- `rdata_valid` out 1: one-cycle completion pulse.
- `fault` out 1: access error; meaningful only when `rdata_valid`=1.
- `bus_req` out 1: memory request.
- `bus_we` out 1: write strobe.
- `bus_addr` out ADDR_W: word-aligned address (bits [1:0]=0).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-steered store data.
- `bus_ack` in 1: memory completed the current request.
- `bus_rdata` in 32: raw read word, valid with `bus_ack`.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE: `req_valid`=1 -> capture request into internal registers. Legal op -> BUS; illegal op -> DONE with fault.
- BUS: `bus_req`=1, and `bus_*` are driven from the captured registers, stable until ack. `bus_ack`=1 -> capture formatted `rdata` -> DONE. Timeout counter reaches TIMEOUT_CYCLES -> DONE with `fault`=1, `rdata`=0.
- DONE: `rdata_valid`=1 and `lsu_stall`=0 for one cycle, then IDLE unconditionally.
- `lsu_stall` = (IDLE & `req_valid`) | BUS. It is combinational and forced to 0 while `reset` is high.
- Illegal ops, which fault without any bus access: loads with funct3 011, 110 or 111; stores with funct3 other than 000, 001 or 010.
- Stores:
  - SB: `bus_wdata`={4{wdata[7:0]}}, `bus_be`=0001<<addr[1:0].
  - SH: `bus_wdata`={2{wdata[15:0]}}, `bus_be`=0011<<{addr[1],1'b0}.
  - SW: `bus_be`=1111.
- Loads: shift `bus_rdata` right by addr[1:0]*8, then:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: word unchanged.
  - `bus_be` = the same mask as the equivalent store.
- Stores: `rdata`=0 at completion.
- `bus_ack` in IDLE or DONE is ignored.
- `rdata` holds its value until the next completion.

## Timing
- Reset values: state IDLE; `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `rdata`, `rdata_valid`, `fault` all 0; timeout counter 0.
- Minimum latency (ack in the first BUS cycle): request seen at cycle 0, BUS at cycle 1, DONE at cycle 2.
  - Result: 2 stall cycles; the pipeline advances at the edge ending cycle 2.
- Each extra cycle without ack adds one stall cycle.
- Illegal or misaligned op: IDLE -> DONE, 1 stall cycle.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1). It clears on entry to BUS and saturates, never wraps.
- Reset asserted mid-BUS: `bus_req` drops asynchronously and no completion pulse is produced.
- Back-to-back ops: the op presented in the cycle after DONE is accepted normally; there is no bubble beyond IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses fault from IDLE -> DONE with no bus access. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- `LSU_MISALIGN_TRAP_EN` undefined: misalignment never faults.
  - Word accesses treat addr[1:0] as 0.
  - Halfword accesses treat addr[0] as 0.
  - The bus access proceeds.

## Structure
- `lsu_pkg` contains:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the state enum;
  - the legal/misaligned decode functions.
- Sub-module `lsu_align` (combinational) does lane steering and extension: inputs funct3, addr[1:0], wdata, bus_rdata; outputs be, steered wdata, formatted rdata.
- FSM, timeout counter and capture registers stay in `load_store_unit`.

## Test plan
- SW addr 0x104, wdata 0xDEADBEEF, ack on first BUS cycle:
  - `bus_addr`=0x104, `bus_be`=1111, `bus_wdata`=0xDEADBEEF;
  - `lsu_stall` high exactly 2 cycles; `rdata_valid` at cycle 2, `fault`=0.
- LB addr 0x103, `bus_rdata`=0x80FF7F01 -> `bus_addr`=0x100, `bus_be`=1000, `rdata`=0xFFFFFF80.
- LHU at the same address and `bus_rdata` with addr 0x102 -> `bus_be`=1100, `rdata`=0x000080FF.
- SB addr 0x101, wdata 0x123456AB -> `bus_be`=0010, `bus_wdata`=0xABABABAB.
- LW with `bus_ack` withheld, TIMEOUT_CYCLES=4 -> `fault`=1, `rdata`=0, stall lasts 5 cycles.
  - Repeat with `reset` pulsed mid-BUS -> `bus_req` drops immediately, no `rdata_valid`.
- LW addr 0x102:
  - With `LSU_MISALIGN_TRAP_EN`: `fault`=1 after 1 stall cycle, `bus_req` never asserted.
  - Without it: `bus_addr`=0x100, `bus_be`=1111, normal completion.
